uart_tx_clken: RTL

Byte-serial UART transmitter that consumes the single-cycle clock-enable pulse from the clock-enable generator as its baud tick. It accepts parallel words over a valid/ready handshake and shifts them out LSB-first as start/data/[parity]/stop frames. Every bit boundary lands on a `clken` pulse. No internal baud divider.

---
 rtl/uart_tx_clken.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_clken.sv
// ---------------------------------------------------------------------------
// uart_tx_clken
//
// Byte-serial UART transmitter paced by an external single-cycle clock
// enable (one pulse per bit period). Words arrive over a valid/ready
// handshake and leave LSB-first as start / data / [parity] / stop frames.
// Every bit boundary coincides with a clken pulse; there is no internal
// baud divider.
//
// Configuration macro:
//   UART_TX_PARITY_EN  defined   -> one parity bit per frame (PARITY_ODD honoured)
//                      undefined -> no parity bit, DATA goes straight to STOP
//
// Parameters:
//   DATA_BITS   data bits per frame, 5..9
//   STOP_BITS   stop bits per frame, 1 or 2
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity builds only)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   clken     in   baud tick, one clk wide
//   tx_data   in   word to send, sampled on handshake only
//   tx_valid  in   upstream has a word
//   tx_ready  out  block can accept a word (high only in IDLE)
//   tx        out  registered serial line, idle high
//   busy      out  high whenever the state is not IDLE
// ---------------------------------------------------------------------------
module uart_tx_clken #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS);

    // Elaboration-time guard on the supported configuration space.
    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_clken: unsupported DATA_BITS/STOP_BITS/PARITY_ODD");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic [DATA_BITS-1:0] sh;       // remaining data bits, next bit in sh[0]
    logic [CW-1:0]        bitcnt;   // index of the data bit currently on tx
    logic                 stopcnt;  // index of the stop bit currently on tx
`ifdef UART_TX_PARITY_EN
    logic                 par;      // parity of the latched word
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            bitcnt   <= '0;
            stopcnt  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                // clken is ignored here, so a pulse coinciding with the
                // handshake never starts the frame; ARM waits for the next.
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        sh       <= tx_data;
`ifdef UART_TX_PARITY_EN
                        par      <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
                        state    <= ARM;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                    end
                end

                ARM: begin
                    if (clken) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (clken) begin
                        tx     <= sh[0];
                        sh     <= sh >> 1;
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                end

                DATA: begin
                    if (clken) begin
                        if (bitcnt < CW'(DATA_BITS - 1)) begin
                            tx     <= sh[0];
                            sh     <= sh >> 1;
                            bitcnt <= bitcnt + CW'(1);
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx      <= 1'b1;
                            stopcnt <= 1'b0;
                            state   <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (clken) begin
                        tx      <= 1'b1;
                        stopcnt <= 1'b0;
                        state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (clken) begin
                        if (stopcnt == 1'(STOP_BITS - 1)) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end else begin
                            stopcnt <= stopcnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
